mem_block_copy: RTL and testbench

//  Bus initiator that copies a block of words from memory to memory over the shared 16-bit tristate bus.

---
 rtl/mem_block_copy_pkg.sv | 21 ++
 rtl/mem_block_copy.sv | 175 +++++++++++++++++
 tb/tb_mem_block_copy.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_block_copy_pkg.sv
// Shared definitions for the block-copy bus initiator and the memory model
// that sits beside it on the tristate bus.
package mem_block_copy_pkg;

  // Highest ROM address. The memory drops writes at or below this address.
  localparam logic [15:0] ROM_TOP_DEF = 16'h00FF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // States that hold or want the memory bus.
  function automatic logic is_active(input state_e s);
    return (s == ST_REQ) || (s == ST_READ) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/mem_block_copy.sv
// Memory-to-memory block copy initiator on the shared tristate bus.
// One word is moved per READ/WRITE pair; the bus is requested from the CPU
// arbiter and re-requested whenever the grant is gone at a word boundary.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; src/dst/len sampled only here
// ST_REQ   | bus_req high, waiting for bus_grant
// ST_READ  | address=src, en=1; bus captured into data_q at the edge
// ST_WRITE | address=dst, load=1, bus driven with data_q; counters step
// ST_DONE  | one-cycle done pulse, bus released
//
// Every output is a flop loaded from the next-state decode, so the pins
// change exactly with the state register and en/drive can never overlap.
module mem_block_copy
  import mem_block_copy_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] ROM_TOP = WIDTH'(ROM_TOP_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] dst,
  input  logic [WIDTH-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             rom_hit,
  output logic             bus_req,
  input  logic             bus_grant,
  output logic [WIDTH-1:0] address,
  output logic             load,
  output logic             en,
  inout  wire  [WIDTH-1:0] bus
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] src_q, src_d;
  logic [WIDTH-1:0] dst_q, dst_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] address_q, address_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic rom_hit_q, rom_hit_d;
  logic bus_req_q, bus_req_d;
  logic load_q, load_d;
  logic en_q, en_d;
  logic drive_q, drive_d;

  // The only driver of the bus from this side; released outside WRITE and
  // immediately on reset because drive_q clears asynchronously.
  assign bus = drive_q ? data_q : {WIDTH{1'bz}};

  assign busy    = busy_q;
  assign done    = done_q;
  assign rom_hit = rom_hit_q;
  assign bus_req = bus_req_q;
  assign address = address_q;
  assign load    = load_q;
  assign en      = en_q;

  // Next-state, counter and sticky-flag update.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    data_d    = data_q;
    rom_hit_d = rom_hit_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d     = src;
          dst_d     = dst;
          rem_d     = len;
          rom_hit_d = 1'b0;
          state_d   = (len == '0) ? ST_DONE : ST_REQ;
        end
      end

      ST_REQ: begin
        if (bus_grant) begin
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        // Memory is driving mem[src] this cycle; a grant drop here still
        // lets the word finish so it is never split.
        data_d  = bus;
        state_d = ST_WRITE;
      end

      ST_WRITE: begin
        src_d = src_q + WIDTH'(1);
        dst_d = dst_q + WIDTH'(1);
        rem_d = rem_q - WIDTH'(1);
        // The write still goes out; the memory itself refuses it.
        if (dst_q <= ROM_TOP) begin
          rom_hit_d = 1'b1;
        end
        if (rem_q == WIDTH'(1)) begin
          state_d = ST_DONE;
        end else if (bus_grant) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered-output decode from the state being entered.
  always_comb begin
    busy_d    = is_active(state_d);
    bus_req_d = is_active(state_d);
    done_d    = (state_d == ST_DONE);
    en_d      = (state_d == ST_READ);
    load_d    = (state_d == ST_WRITE);
    drive_d   = (state_d == ST_WRITE);
    address_d = address_q;
    if (state_d == ST_READ) begin
      address_d = src_d;
    end else if (state_d == ST_WRITE) begin
      address_d = dst_d;
    end
  end

  // State, datapath and output flops with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      address_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rom_hit_q <= 1'b0;
      bus_req_q <= 1'b0;
      load_q    <= 1'b0;
      en_q      <= 1'b0;
      drive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      address_q <= address_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rom_hit_q <= rom_hit_d;
      bus_req_q <= bus_req_d;
      load_q    <= load_d;
      en_q      <= en_d;
      drive_q   <= drive_d;
    end
  end

endmodule

// File: tb/tb_mem_block_copy.sv
// Bench for mem_block_copy: memory model on the tristate bus with a pull-up,
// a grant stub driven from the test, and a word-level reference copy.
module tb_mem_block_copy;
  import mem_block_copy_pkg::*;

  localparam int W     = 16;
  localparam int LIMIT = 3000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  src, dst, len;
  logic          busy, done, rom_hit, bus_req, bus_grant;
  logic [W-1:0]  address;
  logic          load, en;
  wire  [W-1:0]  bus;

  logic [W-1:0]  mem     [0:65535];
  logic [W-1:0]  ref_mem [0:65535];

  int checks   = 0;
  int failures = 0;
  int n_load   = 0;
  int n_en     = 0;

  always #5 clk = ~clk;

  mem_block_copy #(.WIDTH(W), .ROM_TOP(ROM_TOP_DEF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
    .busy(busy), .done(done), .rom_hit(rom_hit), .bus_req(bus_req),
    .bus_grant(bus_grant), .address(address), .load(load), .en(en), .bus(bus)
  );

  // Memory responder: combinational read, clocked write, ROM protected.
  pullup (bus);
  assign bus = en ? mem[address] : {W{1'bz}};

  function automatic logic [W-1:0] init_val(input int a);
    if (a == 0)   return 16'h0101;
    if (a == 1)   return 16'h0300;
    if (a == 500) return 16'd7890;
    if (a == 501) return 16'd8907;
    if (a == 502) return 16'd1;
    return 16'((a * 40503) ^ 16'h5A5A);
  endfunction

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = init_val(a);
  end

  always @(posedge clk) begin
    if (load && (address > ROM_TOP_DEF)) mem[address] <= bus;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: sample #1 after the edge and check the bus invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    if (load) n_load++;
    if (en)   n_en++;
    chk("en_load_exclusive", {31'd0, en && load}, 32'd0);
    if (!en && !load) chk("bus_released", {16'd0, bus}, {16'd0, 16'hFFFF});
  endtask

  // Reference: words copied strictly ascending, addresses wrap, ROM writes dropped.
  function automatic bit ref_copy(input logic [W-1:0] s, input logic [W-1:0] d,
                                  input logic [W-1:0] l);
    bit hit = 1'b0;
    logic [W-1:0] sa, da;
    for (int i = 0; i < int'(l); i++) begin
      sa = s + 16'(i);
      da = d + 16'(i);
      if (da > ROM_TOP_DEF) ref_mem[da] = ref_mem[sa];
      else hit = 1'b1;
    end
    return hit;
  endfunction

  task automatic cmp_mem(input string name);
    int bad = 0;
    for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) bad++;
    chk(name, bad, 0);
  endtask

  // Issue one copy and wait for done; returns latency in edges after the
  // edge that samples start, plus load/en cycle counts.
  task automatic run_copy(input logic [W-1:0] s, input logic [W-1:0] d,
                          input logic [W-1:0] l, input bit rnd_grant,
                          input bit poke_start, output int lat,
                          output int loads, output int ens, output logic busy0);
    int l0, e0;
    bit poked = 1'b0;
    l0 = n_load;
    e0 = n_en;
    src = s; dst = d; len = l; start = 1'b1;
    tick();
    start = 1'b0;
    busy0 = busy;
    lat = 0;
    while (!done && lat < LIMIT) begin
      if (rnd_grant) bus_grant = ($urandom_range(0, 3) != 0);
      if (poke_start && !poked && busy && lat > 2) begin
        start = 1'b1; src = ~s; dst = ~d; len = 16'd7; poked = 1'b1;
      end
      tick();
      start = 1'b0;
      lat++;
    end
    chk("done_timeout", {31'd0, lat >= LIMIT}, 32'd0);
    loads = n_load - l0;
    ens   = n_en - e0;
    bus_grant = 1'b1;
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_not_busy", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] d;
    logic [W-1:0] l;
    logic         hit;
    int           lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, loads, ens, k, base_l, base_e;
    logic busy0;
    bit   hit;

    vecs[0] = '{16'd500,   16'd600,   16'd3, 1'b0, 7};  // basic copy
    vecs[1] = '{16'd500,   16'd650,   16'd0, 1'b0, 0};  // len 0
    vecs[2] = '{16'd500,   16'h0001,  16'd2, 1'b1, 5};  // into ROM
    vecs[3] = '{16'hFFFF,  16'd700,   16'd2, 1'b0, 5};  // source wraps
    vecs[4] = '{16'd500,   16'd501,   16'd4, 1'b0, 9};  // overlap replicates
    vecs[5] = '{16'd1200,  16'h00FF,  16'd2, 1'b1, 5};  // ROM_TOP boundary
    vecs[6] = '{16'd1300,  16'h0100,  16'd1, 1'b0, 3};  // just above ROM
    vecs[7] = '{16'd1400,  16'hFFFF,  16'd2, 1'b1, 5};  // dest wraps into ROM

    for (int a = 0; a < 65536; a++) ref_mem[a] = init_val(a);

    rst_n = 1'b0; start = 1'b0; bus_grant = 1'b0;
    src = '0; dst = '0; len = '0;
    tick(); tick();
    chk("reset_outputs", {26'd0, busy, done, rom_hit, bus_req, load, en}, 32'd0);
    chk("reset_address", {16'd0, address}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_grant = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      void'(ref_copy(vecs[i].s, vecs[i].d, vecs[i].l));
      run_copy(vecs[i].s, vecs[i].d, vecs[i].l, 1'b0, 1'b0, lat, loads, ens, busy0);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_rom_hit", i), {31'd0, rom_hit}, {31'd0, vecs[i].hit});
      chk($sformatf("vec%0d_loads", i), loads, int'(vecs[i].l));
      chk($sformatf("vec%0d_ens", i), ens, int'(vecs[i].l));
      chk($sformatf("vec%0d_busy_after_start", i), {31'd0, busy0},
          {31'd0, vecs[i].l != 0});
      cmp_mem($sformatf("vec%0d_memory", i));
    end
    chk("copy_600", {16'd0, mem[600]}, 32'd7890);
    chk("copy_601", {16'd0, mem[601]}, 32'd8907);
    chk("copy_602", {16'd0, mem[602]}, 32'd1);
    chk("rom_word1_kept", {16'd0, mem[1]}, 32'h0300);
    chk("wrap_701", {16'd0, mem[701]}, 32'h0101);
    chk("overlap_504", {16'd0, mem[504]}, 32'd7890);

    // Grant held off, then withdrawn during the second word's READ.
    hit = ref_copy(16'd500, 16'd800, 16'd3);
    bus_grant = 1'b0;
    base_l = n_load; base_e = n_en;
    src = 16'd500; dst = 16'd800; len = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("nogrant_wait", {28'd0, bus_req, en, load, busy}, 32'b1001);
    bus_grant = 1'b1;
    k = 0;
    while (!(en && (n_en - base_e) == 2) && k < 50) begin tick(); k++; end
    chk("drop_reach_read2", {31'd0, en}, 32'd1);
    bus_grant = 1'b0;
    tick();
    chk("drop_write_follows", {30'd0, load, en}, 32'b10);
    tick();
    chk("drop_back_to_req", {29'd0, bus_req, load, en}, 32'b100);
    tick(); tick();
    chk("drop_req_holds", {28'd0, bus_req, load, en, busy}, 32'b1001);
    bus_grant = 1'b1;
    k = 0;
    while (!done && k < 50) begin tick(); k++; end
    chk("drop_done", {31'd0, done}, 32'd1);
    chk("drop_rom_hit", {31'd0, rom_hit}, {31'd0, hit});
    tick();
    chk("drop_loads", n_load - base_l, 3);
    cmp_mem("drop_memory");

    // Reset asserted in the middle of the second WRITE of a 5-word copy.
    void'(ref_copy(16'd900, 16'd1000, 16'd1));
    base_l = n_load;
    src = 16'd900; dst = 16'd1000; len = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!(load && (n_load - base_l) == 2) && k < 50) begin tick(); k++; end
    chk("rst_reach_write2", {31'd0, load}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {27'd0, load, en, busy, bus_req, done}, 32'd0);
    chk("rst_bus_released", {16'd0, bus}, {16'd0, 16'hFFFF});
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_no_done", {30'd0, done, busy}, 32'd0);
    tick();
    cmp_mem("rst_partial_memory");
    void'(ref_copy(16'd900, 16'd1100, 16'd2));
    run_copy(16'd900, 16'd1100, 16'd2, 1'b0, 1'b0, lat, loads, ens, busy0);
    chk("rst_recover_latency", lat, 5);
    cmp_mem("rst_recover_memory");

    // Random copies with a jittering grant and a stray start while busy.
    for (int r = 0; r < 6; r++) begin
      logic [W-1:0] rs, rd, rl;
      rs = 16'($urandom);
      rd = 16'($urandom);
      rl = 16'($urandom_range(1, 24));
      if (r == 1) rd = 16'($urandom_range(0, 300));
      hit = ref_copy(rs, rd, rl);
      run_copy(rs, rd, rl, 1'b1, 1'b1, lat, loads, ens, busy0);
      chk($sformatf("rnd%0d_rom_hit", r), {31'd0, rom_hit}, {31'd0, hit});
      chk($sformatf("rnd%0d_loads", r), loads, int'(rl));
      chk($sformatf("rnd%0d_ens", r), ens, int'(rl));
      cmp_mem($sformatf("rnd%0d_memory", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
